voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
// Gate-side driver for a bank of ADSR envelope voices. Accepts note-on/off events over a valid/ready handshake,
// assigns each note to a voice, and drives that voice's Gate and note number. Voice Running flags tell it which
// voices are fully silent. Sits between the note-event source and NUM_VOICES envelope/oscillator voices.
// PARAMETERS
// NUM_VOICES     4   number of voices driven (1..16)
// NOTE_W         7   note-number width
// RETRIG_CYCLES  2   cycles Gate is held low before re-raising on retrigger/steal (>=1)
// STAMP_W        8   width of allocation-age timestamps
// PORTS
// Clock         in   1                  system clock, all logic on rising edge
// Reset         in   1                  synchronous, active-low reset
// NoteValid     in   1                  event present
// NoteOn        in   1                  1 = note-on, 0 = note-off (qualified by NoteValid)
// Note          in   NOTE_W             note number of event
// NoteReady     out  1                  block can accept an event this cycle
// VoiceRunning  in   NUM_VOICES         per-voice Running from envelope; 0 = voice silent
// VoiceGate     out  NUM_VOICES         per-voice Gate to envelope
// VoiceNote     out  NUM_VOICES*NOTE_W  per-voice note number, voice i at [i*NOTE_W +: NOTE_W]
// StealPulse    out  1                  1-cycle pulse when a gated voice was stolen
// BUSY          out  1                  FSM not in IDLE
// BEHAVIOUR
// - Reset (Reset==0 at edge): VoiceGate=0, VoiceNote=0, stamps=0, StampCnt=0, StealPulse=0, BUSY=0, NoteReady=1,
//   FSM=IDLE. Reset mid-RETRIG abandons the event. Reset dominates all other inputs.
// - Handshake: event accepted on edge where NoteValid&&NoteReady; Note/NoteOn captured. NoteReady = (FSM==IDLE).
// - FSM states: IDLE, EVAL, RETRIG. IDLE --accept--> EVAL. EVAL --> IDLE or RETRIG. RETRIG --count done--> IDLE.
// - Voice classes: GATED (Gate=1), RELEASING (Gate=0,Running=1), FREE (Gate=0,Running=0).
// - EVAL, note-off: lowest-index GATED voice with VoiceNote==Note gets Gate<=0; no match -> event dropped. ->IDLE.
// - EVAL, note-on, priority order:
//   1. voice (any class) with VoiceNote==Note, lowest index, and Gate=1 or Running=1 -> retrigger that voice.
//   2. lowest-index FREE voice -> VoiceNote<=Note, Gate<=1 at EVAL edge -> IDLE.
//   3. RELEASING voice with oldest stamp -> VoiceNote<=Note, Gate<=1 -> IDLE.
//   4. GATED voice with oldest stamp -> steal: StealPulse=1 for one cycle, then retrigger path.
//   Retrigger path: Gate<=0 and VoiceNote<=Note at EVAL edge; RETRIG holds Gate low RETRIG_CYCLES cycles,
//   Gate<=1 on last RETRIG edge -> IDLE. (Envelope restarts only on a Gate rising edge.)
// - Age: on every voice assignment (rules 1-4) stamp[v]<=StampCnt, StampCnt<=StampCnt+1 (wraps mod 2^STAMP_W).
//   Age = (StampCnt - stamp[v]) mod 2^STAMP_W; oldest = largest age; ties -> lowest index.
// - Latency: accept at edge T; EVAL edge T+1 -> Gate visible after T+1 on direct assign; NoteReady high again at T+2.
//   Retrigger: Gate low after T+1, high after T+1+RETRIG_CYCLES; NoteReady high from T+2+RETRIG_CYCLES.
// - VoiceRunning is sampled only in EVAL; changes in other states have no effect. Gate of other voices is
//   never touched by an event for a different voice.
// - NOTE_W match is exact bitwise; note 0 is a valid note (VoiceNote reset value 0 is matched only via rule 1 if
//   that voice is GATED or RELEASING).
// TESTING (NUM_VOICES=4, RETRIG_CYCLES=2)
// 1. After reset, on(60),on(64),on(67) with Running following Gate -> voices 0,1,2 gated, notes 60/64/67, Ready 1 every 2nd cycle.
// 2. Voice1 off(64): Gate1 falls next EVAL; hold Running1=1, on(72) -> goes to free voice3, not voice1.
// 3. All 4 gated (60,64,67,72 in order), on(76) -> StealPulse, voice0 Gate low 2 cycles then high, VoiceNote0=76.
// 4. Voice2 gated 67, on(67) -> voice2 Gate 0 for 2 cycles then 1; no other voice changes; StealPulse=0.
// 5. off(99) with no match -> no Gate change, Ready back after 2 cycles; NoteValid held while Ready=0 not accepted.
// 6. Reset asserted during RETRIG -> next cycle all Gates 0, Ready 1; StampCnt wrap from 255 -> steal still picks oldest.

Source files
------------

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Assigns note-on/off events to a bank of ADSR envelope voices and drives each
// voice's Gate and note number. Events arrive over a valid/ready handshake and
// are processed one at a time by a small IDLE -> EVAL -> (RETRIG) -> IDLE FSM.
//
// Voice classes as seen in EVAL:
//   GATED     : Gate = 1
//   RELEASING : Gate = 0, Running = 1
//   FREE      : Gate = 0, Running = 0
//
// Note-on priority: same-note retrigger, then lowest free voice, then oldest
// releasing voice, then steal the oldest gated voice. A retrigger or steal holds
// the voice's Gate low for RETRIG_CYCLES cycles so the envelope sees a fresh
// rising edge.
//
// Ports:
//   Clock         in   system clock, rising edge
//   Reset         in   synchronous, active-low reset
//   NoteValid     in   event present
//   NoteOn        in   1 = note-on, 0 = note-off
//   Note          in   note number of the event
//   NoteReady     out  event can be accepted this cycle (FSM idle)
//   VoiceRunning  in   per-voice Running flag from the envelopes
//   VoiceGate     out  per-voice Gate
//   VoiceNote     out  per-voice note number, voice i at [i*NOTE_W +: NOTE_W]
//   StealPulse    out  one-cycle pulse when a gated voice was stolen
//   BUSY          out  FSM not idle
// -----------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES    = 4,
    parameter int NOTE_W        = 7,
    parameter int RETRIG_CYCLES = 2,
    parameter int STAMP_W       = 8
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         NoteValid,
    input  logic                         NoteOn,
    input  logic [NOTE_W-1:0]            Note,
    output logic                         NoteReady,
    input  logic [NUM_VOICES-1:0]        VoiceRunning,
    output logic [NUM_VOICES-1:0]        VoiceGate,
    output logic [NUM_VOICES*NOTE_W-1:0] VoiceNote,
    output logic                         StealPulse,
    output logic                         BUSY
);

    localparam int VI_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RT_LAST = CNT_W'(RETRIG_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EVAL   = 2'd1;
    localparam logic [1:0] ST_RETRIG = 2'd2;

    // State
    logic [1:0]            state_q,     state_d;
    logic [NOTE_W-1:0]     ev_note_q,   ev_note_d;
    logic                  ev_on_q,     ev_on_d;
    logic [NUM_VOICES-1:0] gate_q,      gate_d;
    logic [NOTE_W-1:0]     note_q       [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d       [NUM_VOICES];
    logic [STAMP_W-1:0]    stamp_q      [NUM_VOICES];
    logic [STAMP_W-1:0]    stamp_d      [NUM_VOICES];
    logic [STAMP_W-1:0]    stamp_cnt_q, stamp_cnt_d;
    logic                  steal_q,     steal_d;
    logic [VI_W-1:0]       rt_voice_q,  rt_voice_d;
    logic [CNT_W-1:0]      rt_cnt_q,    rt_cnt_d;

    // Candidate search results
    logic                  on_hit,   off_hit,  free_hit, rel_hit,  gat_hit;
    logic [VI_W-1:0]       on_idx,   off_idx,  free_idx, rel_idx,  gat_idx;
    logic [STAMP_W-1:0]    rel_age,  gat_age,  age;

    // Allocation decision temporaries
    logic [VI_W-1:0]       tgt;
    logic                  assign_en;
    logic                  retrig;

    // -------------------------------------------------------------------------
    // Candidate search. All scans run lowest index first; a later voice only
    // replaces an earlier one on a strictly larger age, so ties go to the lower
    // index. Age is modular so a wrapped StampCnt still orders correctly.
    // -------------------------------------------------------------------------
    always_comb begin
        on_hit   = 1'b0;  on_idx   = '0;
        off_hit  = 1'b0;  off_idx  = '0;
        free_hit = 1'b0;  free_idx = '0;
        rel_hit  = 1'b0;  rel_idx  = '0;  rel_age = '0;
        gat_hit  = 1'b0;  gat_idx  = '0;  gat_age = '0;
        age      = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            age = stamp_cnt_q - stamp_q[i];
            if (!on_hit && (note_q[i] == ev_note_q) && (gate_q[i] || VoiceRunning[i])) begin
                on_hit = 1'b1;
                on_idx = VI_W'(i);
            end
            if (!off_hit && gate_q[i] && (note_q[i] == ev_note_q)) begin
                off_hit = 1'b1;
                off_idx = VI_W'(i);
            end
            if (!free_hit && !gate_q[i] && !VoiceRunning[i]) begin
                free_hit = 1'b1;
                free_idx = VI_W'(i);
            end
            if (!gate_q[i] && VoiceRunning[i] && (!rel_hit || (age > rel_age))) begin
                rel_hit = 1'b1;
                rel_idx = VI_W'(i);
                rel_age = age;
            end
            if (gate_q[i] && (!gat_hit || (age > gat_age))) begin
                gat_hit = 1'b1;
                gat_idx = VI_W'(i);
                gat_age = age;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ev_note_d   = ev_note_q;
        ev_on_d     = ev_on_q;
        gate_d      = gate_q;
        note_d      = note_q;
        stamp_d     = stamp_q;
        stamp_cnt_d = stamp_cnt_q;
        steal_d     = 1'b0;
        rt_voice_d  = rt_voice_q;
        rt_cnt_d    = rt_cnt_q;
        tgt         = '0;
        assign_en   = 1'b0;
        retrig      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (NoteValid) begin
                    ev_note_d = Note;
                    ev_on_d   = NoteOn;
                    state_d   = ST_EVAL;
                end
            end

            ST_EVAL: begin
                state_d = ST_IDLE;
                if (!ev_on_q) begin
                    // Unmatched note-off is silently dropped.
                    if (off_hit) begin
                        gate_d[off_idx] = 1'b0;
                    end
                end else begin
                    if (on_hit) begin
                        tgt       = on_idx;
                        assign_en = 1'b1;
                        retrig    = 1'b1;
                    end else if (free_hit) begin
                        tgt       = free_idx;
                        assign_en = 1'b1;
                    end else if (rel_hit) begin
                        tgt       = rel_idx;
                        assign_en = 1'b1;
                    end else if (gat_hit) begin
                        tgt       = gat_idx;
                        assign_en = 1'b1;
                        retrig    = 1'b1;
                        steal_d   = 1'b1;
                    end

                    if (assign_en) begin
                        note_d[tgt]  = ev_note_q;
                        stamp_d[tgt] = stamp_cnt_q;
                        stamp_cnt_d  = stamp_cnt_q + 1'b1;
                        if (retrig) begin
                            // Drop Gate now; RETRIG raises it again so the
                            // envelope sees a clean rising edge.
                            gate_d[tgt] = 1'b0;
                            rt_voice_d  = tgt;
                            rt_cnt_d    = '0;
                            state_d     = ST_RETRIG;
                        end else begin
                            gate_d[tgt] = 1'b1;
                        end
                    end
                end
            end

            ST_RETRIG: begin
                if (rt_cnt_q == RT_LAST) begin
                    gate_d[rt_voice_q] = 1'b1;
                    state_d            = ST_IDLE;
                end else begin
                    rt_cnt_d = rt_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            ev_note_q   <= '0;
            ev_on_q     <= 1'b0;
            gate_q      <= '0;
            stamp_cnt_q <= '0;
            steal_q     <= 1'b0;
            rt_voice_q  <= '0;
            rt_cnt_q    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i]  <= '0;
                stamp_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ev_note_q   <= ev_note_d;
            ev_on_q     <= ev_on_d;
            gate_q      <= gate_d;
            stamp_cnt_q <= stamp_cnt_d;
            steal_q     <= steal_d;
            rt_voice_q  <= rt_voice_d;
            rt_cnt_q    <= rt_cnt_d;
            note_q      <= note_d;
            stamp_q     <= stamp_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        VoiceNote = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            VoiceNote[i*NOTE_W +: NOTE_W] = note_q[i];
        end
    end

    assign VoiceGate  = gate_q;
    assign StealPulse = steal_q;
    assign NoteReady  = (state_q == ST_IDLE);
    assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_voice_allocator.sv
`timescale 1ns/1ps
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int NW = 7;
    localparam int RC = 2;
    localparam int SW = 8;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic              NoteValid = 1'b0;
    logic              NoteOn = 1'b0;
    logic [NW-1:0]     Note = '0;
    logic              NoteReady;
    logic [NV-1:0]     VoiceRunning = '0;
    logic [NV-1:0]     VoiceGate;
    logic [NV*NW-1:0]  VoiceNote;
    logic              StealPulse;
    logic              BUSY;

    voice_allocator #(
        .NUM_VOICES(NV), .NOTE_W(NW), .RETRIG_CYCLES(RC), .STAMP_W(SW)
    ) dut (
        .Clock(Clock), .Reset(Reset), .NoteValid(NoteValid), .NoteOn(NoteOn),
        .Note(Note), .NoteReady(NoteReady), .VoiceRunning(VoiceRunning),
        .VoiceGate(VoiceGate), .VoiceNote(VoiceNote), .StealPulse(StealPulse),
        .BUSY(BUSY)
    );

    always #5 Clock = ~Clock;

    // Expected outcome of one accepted event
    typedef struct {
        logic [NV-1:0]    gate;   // gate vector once the event completes
        logic [NV*NW-1:0] notes;  // note vector once the event completes
        int               busy;   // cycles NoteReady is low
        int               steal;  // StealPulse cycles
        int               tgt;    // voice assigned by a note-on, -1 otherwise
        int               low;    // cycles target Gate is held low after EVAL
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: plain per-voice arrays
    bit   m_gate  [NV];
    int   m_note  [NV];
    int   m_stamp [NV];
    int   m_cnt;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_gate[v] = 1'b0; m_note[v] = 0; m_stamp[v] = 0;
        end
        m_cnt = 0;
    endtask

    function automatic int m_age(input int v);
        return (m_cnt - m_stamp[v] + (1 << SW)) % (1 << SW);
    endfunction

    function automatic logic [NV-1:0] m_gvec();
        logic [NV-1:0] g;
        for (int v = 0; v < NV; v++) g[v] = m_gate[v];
        return g;
    endfunction

    task automatic model_event(input bit on, input int n, input logic [NV-1:0] run, output exp_t e);
        int v;
        bit rt;
        e.busy = 1; e.steal = 0; e.tgt = -1; e.low = 0;
        if (!on) begin
            for (int i = 0; i < NV; i++)
                if (m_gate[i] && m_note[i] == n) begin m_gate[i] = 1'b0; break; end
        end else begin
            v = -1; rt = 1'b0;
            for (int i = 0; i < NV; i++)
                if (m_note[i] == n && (m_gate[i] || run[i])) begin v = i; rt = 1'b1; break; end
            if (v < 0)
                for (int i = 0; i < NV; i++)
                    if (!m_gate[i] && !run[i]) begin v = i; break; end
            if (v < 0)
                for (int i = 0; i < NV; i++)
                    if (!m_gate[i] && run[i] && (v < 0 || m_age(i) > m_age(v))) v = i;
            if (v < 0) begin
                for (int i = 0; i < NV; i++)
                    if (m_gate[i] && (v < 0 || m_age(i) > m_age(v))) v = i;
                rt = 1'b1; e.steal = 1;
            end
            m_note[v]  = n;
            m_stamp[v] = m_cnt;
            m_cnt      = (m_cnt + 1) % (1 << SW);
            m_gate[v]  = 1'b1;
            e.tgt = v;
            if (rt) begin e.busy = 1 + RC; e.low = RC; end
        end
        e.gate = m_gvec();
        for (int i = 0; i < NV; i++) e.notes[i*NW +: NW] = NW'(m_note[i]);
    endtask

    task automatic summary_and_finish();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Issue one event; NoteValid stays high with junk afterwards so any
    // acceptance while busy would desynchronise the scoreboard.
    task automatic send(input bit on, input logic [NW-1:0] n, input logic [NV-1:0] run);
        exp_t e;
        int   w = 0;
        @(negedge Clock);
        while (!NoteReady && w < 50) begin @(negedge Clock); w++; end
        if (!NoteReady) begin
            chk("ready_timeout", 0, 1);
            summary_and_finish();
        end
        NoteValid = 1'b1; NoteOn = on; Note = n; VoiceRunning = run;
        model_event(on, int'(n), run, e);
        exp_q.push_back(e);
        @(posedge Clock); #1;
        NoteOn = 1'($urandom_range(0, 1));
        Note   = NW'($urandom_range(0, 127));
    endtask

    task automatic quiesce();
        int w = 0;
        @(negedge Clock);
        while (!NoteReady && w < 50) begin @(negedge Clock); w++; end
        NoteValid = 1'b0;
        if (!NoteReady) begin
            chk("quiesce_timeout", 0, 1);
            summary_and_finish();
        end
    endtask

    task automatic do_reset();
        @(posedge Clock); #1;
        Reset = 1'b0; NoteValid = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        chk("rst_gate",  VoiceGate, 0);
        chk("rst_notes", VoiceNote, 0);
        chk("rst_ready", NoteReady, 1);
        chk("rst_busy",  BUSY, 0);
        chk("rst_steal", StealPulse, 0);
        model_reset();
        VoiceRunning = '0;
        @(posedge Clock); #1;
        Reset = 1'b1;
    endtask

    // Monitor: one transaction spans the NoteReady-low window plus the first
    // ready sample after it.
    bit   mon_in = 1'b0;
    int   mon_bsy, mon_stl, mon_low, mon_idx, mon_tgt;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                mon_in = 1'b0;
                exp_q.delete();
            end else if (!NoteReady) begin
                if (!mon_in) begin
                    mon_in = 1'b1; mon_bsy = 0; mon_stl = 0; mon_low = 0; mon_idx = 0;
                    mon_tgt = (exp_q.size() > 0) ? exp_q[0].tgt : -1;
                end
                mon_bsy++;
                mon_stl += int'(StealPulse);
                if (mon_idx >= 1 && mon_tgt >= 0 && !VoiceGate[mon_tgt]) mon_low++;
                mon_idx++;
            end else if (mon_in) begin
                mon_in = 1'b0;
                mon_stl += int'(StealPulse);
                if (mon_tgt >= 0 && !VoiceGate[mon_tgt]) mon_low++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("gate",  VoiceGate, mon_e.gate);
                    chk("notes", VoiceNote, mon_e.notes);
                    chk("busy_cycles", mon_bsy, mon_e.busy);
                    chk("steal_pulses", mon_stl, mon_e.steal);
                    if (mon_e.tgt >= 0) chk("gate_low_cycles", mon_low, mon_e.low);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit on;
        logic [NW-1:0] n;
        model_reset();
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("init_gate",  VoiceGate, 0);
        chk("init_notes", VoiceNote, 0);
        chk("init_ready", NoteReady, 1);
        chk("init_busy",  BUSY, 0);
        chk("init_steal", StealPulse, 0);
        @(posedge Clock); #1;
        Reset = 1'b1;

        // Three notes onto an empty bank
        send(1'b1, 7'd60, m_gvec());
        send(1'b1, 7'd64, m_gvec());
        send(1'b1, 7'd67, m_gvec());
        quiesce();
        chk("t1_gate", VoiceGate, 4'b0111);
        chk("t1_note2", VoiceNote[2*NW +: NW], 67);

        // Releasing voice 1 is skipped in favour of free voice 3
        send(1'b0, 7'd64, m_gvec());
        send(1'b1, 7'd72, m_gvec() | 4'b0010);
        quiesce();
        chk("t2_gate", VoiceGate, 4'b1101);
        chk("t2_note3", VoiceNote[3*NW +: NW], 72);

        // Full bank: steal the oldest voice
        do_reset();
        send(1'b1, 7'd60, m_gvec());
        send(1'b1, 7'd64, m_gvec());
        send(1'b1, 7'd67, m_gvec());
        send(1'b1, 7'd72, m_gvec());
        send(1'b1, 7'd76, m_gvec());
        quiesce();
        chk("t3_gate", VoiceGate, 4'b1111);
        chk("t3_note0", VoiceNote[0 +: NW], 76);

        // Same-note retrigger on voice 2
        send(1'b1, 7'd67, m_gvec());
        quiesce();
        chk("t4_note2", VoiceNote[2*NW +: NW], 67);

        // Unmatched note-off
        send(1'b0, 7'd99, m_gvec());
        quiesce();
        chk("t5_gate", VoiceGate, 4'b1111);

        // Reset during RETRIG abandons the event
        send(1'b1, 7'd64, m_gvec());
        do_reset();

        // Randomised traffic, long enough to wrap the stamp counter
        for (int k = 0; k < 600; k++) begin
            on = ($urandom_range(0, 9) < 6);
            n  = ($urandom_range(0, 15) == 0) ? 7'd0 : NW'(58 + $urandom_range(0, 11));
            send(on, n, m_gvec() | NV'($urandom_range(0, 15)));
            if ($urandom_range(0, 19) == 0) quiesce();
        end
        quiesce();

        w = 0;
        while ((exp_q.size() != 0 || mon_in) && w < 20) begin @(negedge Clock); w++; end
        chk("scoreboard_drained", exp_q.size(), 0);
        summary_and_finish();
    end

endmodule
